// File: rtl/fir_l2_pkg.sv
// Shared types and constants for the L=2 fast-FIR input deinterleaver.
// The pair struct is sized by FIR_L2_DW; the deinterleaver's DATA_IN_WIDTH must equal it.
package fir_l2_pkg;

  localparam int FIR_L2_L  = 2;
  localparam int FIR_L2_DW = 16;

  // A sum of L samples grows by clog2(L) bits.
  function automatic int fir_l2_sum_w(input int data_w);
    return data_w + $clog2(FIR_L2_L);
  endfunction

  localparam int FIR_L2_SW = fir_l2_sum_w(FIR_L2_DW);

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } fir_l2_phase_e;

  typedef struct packed {
    logic signed [FIR_L2_DW-1:0] even;
    logic signed [FIR_L2_DW-1:0] odd;
    logic signed [FIR_L2_SW-1:0] sum;
  } fir_l2_pair_t;

  localparam fir_l2_pair_t FIR_L2_PAIR_ZERO = '{
    even: {FIR_L2_DW{1'b0}},
    odd:  {FIR_L2_DW{1'b0}},
    sum:  {FIR_L2_SW{1'b0}}
  };

endpackage

// File: rtl/fir_l2_pair_fifo.sv
// First-word-fall-through FIFO of polyphase pairs; head reads as zero when empty.
// Full and empty are told apart by an extra pointer bit.
module fir_l2_pair_fifo
  import fir_l2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  fir_l2_pair_t             i_push_data,
  input  logic                     i_pop,
  output fir_l2_pair_t             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fir_l2_pair_t r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [AW:0]  r_level;
  logic         w_full;
  logic         w_empty;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_head  = w_empty ? FIR_L2_PAIR_ZERO : r_mem[r_rptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= {(AW+1){1'b0}};
      r_rptr  <= {(AW+1){1'b0}};
      r_level <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= FIR_L2_PAIR_ZERO;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_push_data;
        r_wptr                <= r_wptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + PTR_ONE;
        2'b01:   r_level <= r_level - PTR_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fir_l2_input_deinterleaver.sv
// Serial-to-polyphase feeder for the L=2 fast FIR: pairs samples, pre-adds, buffers pairs.
// Optional DEINT_PAIR_CNT_EN adds a 32-bit count of popped pairs on pair_count.
module fir_l2_input_deinterleaver
  import fir_l2_pkg::*;
#(
  parameter int DATA_IN_WIDTH   = FIR_L2_DW,
  parameter int PAIR_FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_IN_WIDTH-1:0]           data_in,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_IN_WIDTH-1:0]           out_even,
  output logic [DATA_IN_WIDTH-1:0]           out_odd,
  output logic [DATA_IN_WIDTH:0]             out_sum,
  output logic [$clog2(PAIR_FIFO_DEPTH):0]   fifo_level
`ifdef DEINT_PAIR_CNT_EN
  ,
  output logic [31:0]                        pair_count
`endif
);

  localparam int W  = DATA_IN_WIDTH;
  localparam int LW = $clog2(PAIR_FIFO_DEPTH) + 1;

  fir_l2_phase_e  r_phase;
  logic [W-1:0]   r_hold;
  fir_l2_pair_t   w_push_pair;
  fir_l2_pair_t   w_head;
  logic           w_full;
  logic           w_empty;
  logic [LW-1:0]  w_level;
  logic           w_pop;
  logic           w_in_ready;
  logic           w_accept;
  logic           w_flush_push;
  logic           w_push;
  logic [W-1:0]   w_odd;
  logic [W:0]     w_sum;

  assign w_pop      = !w_empty && out_ready;
  assign w_in_ready = (r_phase == PH_EVEN) ? 1'b1 : (!w_full || w_pop);
  assign w_accept   = in_valid && w_in_ready;
  // A real odd sample takes priority; flush only closes the pair when no sample is offered.
  assign w_flush_push = (r_phase == PH_ODD) && !in_valid && flush && (!w_full || w_pop);
  assign w_push       = ((r_phase == PH_ODD) && w_accept) || w_flush_push;

  assign w_odd = in_valid ? data_in : {W{1'b0}};
  assign w_sum = {r_hold[W-1], r_hold} + {w_odd[W-1], w_odd};

  assign w_push_pair.even = r_hold;
  assign w_push_pair.odd  = w_odd;
  assign w_push_pair.sum  = w_sum;

  fir_l2_pair_fifo #(
    .DEPTH (PAIR_FIFO_DEPTH)
  ) u_pair_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_pair),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level)
  );

  // Phase FSM with the even-sample hold register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= PH_EVEN;
      r_hold  <= {W{1'b0}};
    end else begin
      case (r_phase)
        PH_EVEN: begin
          if (w_accept) begin
            r_hold  <= data_in;
            r_phase <= PH_ODD;
          end
        end
        PH_ODD: begin
          if (w_push) begin
            r_phase <= PH_EVEN;
          end
        end
        default: r_phase <= PH_EVEN;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = !w_empty;
  assign out_even   = w_head.even;
  assign out_odd    = w_head.odd;
  assign out_sum    = w_head.sum;
  assign fifo_level = w_level;

`ifdef DEINT_PAIR_CNT_EN
  logic [31:0] r_pair_count;

  // Popped-pair counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pair_count <= 32'd0;
    end else if (w_pop) begin
      r_pair_count <= r_pair_count + 32'd1;
    end else begin
      r_pair_count <= r_pair_count;
    end
  end

  assign pair_count = r_pair_count;
`endif

endmodule

// File: tb/tb_fir_l2_input_deinterleaver.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_fir_l2_input_deinterleaver;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_even;
  logic [W-1:0]  out_odd;
  logic [W:0]    out_sum;
  logic [LW-1:0] fifo_level;
`ifdef DEINT_PAIR_CNT_EN
  logic [31:0]   pair_count;
`endif

  always #5 clk = ~clk;

  fir_l2_input_deinterleaver #(
    .DATA_IN_WIDTH   (W),
    .PAIR_FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_even   (out_even),
    .out_odd    (out_odd),
    .out_sum    (out_sum),
    .fifo_level (fifo_level)
`ifdef DEINT_PAIR_CNT_EN
    ,
    .pair_count (pair_count)
`endif
  );

  typedef struct {
    logic [W-1:0] e;
    logic [W-1:0] o;
  } pair_m_t;

  pair_m_t      q[$];
  bit           pending;
  logic [W-1:0] hold;
  int           pops;
  int           n_chk  = 0;
  int           n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W:0] pair_sum(input logic [W-1:0] e, input logic [W-1:0] o);
    int s;
    s = int'($signed(e)) + int'($signed(o));
    return s[W:0];
  endfunction

  function automatic bit m_in_ready();
    return !pending || (q.size() < D) || (q.size() > 0 && out_ready);
  endfunction

  task automatic model_clear();
    q.delete();
    pending = 1'b0;
    hold    = '0;
    pops    = 0;
  endtask

  task automatic check_outputs();
    if (q.size() > 0) begin
      check_val("out_valid", 64'(out_valid), 64'd1);
      check_val("out_even",  64'(out_even),  64'(q[0].e));
      check_val("out_odd",   64'(out_odd),   64'(q[0].o));
      check_val("out_sum",   64'(out_sum),   64'(pair_sum(q[0].e, q[0].o)));
    end else begin
      check_val("out_valid_empty", 64'(out_valid), 64'd0);
      check_val("out_zero", 64'({out_even, out_odd, out_sum}), 64'd0);
    end
    check_val("fifo_level", 64'(fifo_level), 64'(q.size()));
    check_val("in_ready",   64'(in_ready),   64'(m_in_ready()));
`ifdef DEINT_PAIR_CNT_EN
    check_val("pair_count", 64'(pair_count), 64'(pops));
`endif
  endtask

  // Behaviour at one rising edge: pop the head, then form/push pairs.
  task automatic model_edge();
    int      sz;
    bit      pop;
    bit      acc;
    bit      do_push;
    pair_m_t p;
    sz      = q.size();
    pop     = (sz > 0) && out_ready;
    acc     = in_valid && m_in_ready();
    do_push = 1'b0;
    if (!pending) begin
      if (acc) begin
        hold    = data_in;
        pending = 1'b1;
      end
    end else if (acc) begin
      p.e = hold; p.o = data_in; do_push = 1'b1; pending = 1'b0;
    end else if (!in_valid && flush && (sz < D || pop)) begin
      p.e = hold; p.o = '0; do_push = 1'b1; pending = 1'b0;
    end
    if (pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (do_push) q.push_back(p);
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    in_valid  = v;
    data_in   = d;
    flush     = f;
    out_ready = r;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [W-1:0] e, input logic [W-1:0] o,
                             input logic [W:0] s);
    check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_val({tag, "_even"},  64'(out_even),  64'(e));
    check_val({tag, "_odd"},   64'(out_odd),   64'(o));
    check_val({tag, "_sum"},   64'(out_sum),   64'(s));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    data_in   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #2;
    model_clear();
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] d;
    model_clear();
    in_valid  = 1'b0;
    data_in   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #12;
    check_outputs();
    check_val("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic pairing with one-cycle visibility.
    cycle(1'b1, 16'd1, 1'b0, 1'b0);
    cycle(1'b1, 16'd2, 1'b0, 1'b0);
    expect_head("basic12", 16'd1, 16'd2, 17'd3);
    cycle(1'b1, 16'd3, 1'b0, 1'b1);
    cycle(1'b1, 16'd4, 1'b0, 1'b1);
    expect_head("basic34", 16'd3, 16'd4, 17'd7);
    drain(2);

    // Sum width and sign extension.
    cycle(1'b1, 16'h7FFF, 1'b0, 1'b0);
    cycle(1'b1, 16'h7FFF, 1'b0, 1'b0);
    expect_head("maxpos", 16'h7FFF, 16'h7FFF, 17'h0FFFE);
    drain(1);
    cycle(1'b1, 16'h8000, 1'b0, 1'b0);
    cycle(1'b1, 16'h8000, 1'b0, 1'b0);
    expect_head("maxneg", 16'h8000, 16'h8000, 17'h10000);
    drain(2);

    // Backpressure: ten samples into a four-pair FIFO.
    for (int i = 1; i <= 10; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
    check_val("bp_level", 64'(fifo_level), 64'd4);
    check_val("bp_in_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 16'd10, 1'b0, 1'b1);
    check_val("bp_level_pushpop", 64'(fifo_level), 64'd4);
    drain(6);

    // Flush behaviour.
    cycle(1'b1, 16'd5, 1'b0, 1'b0);
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    expect_head("flush5", 16'd5, 16'd0, 17'd5);
    drain(2);
    cycle(1'b0, 16'd0, 1'b1, 1'b1);
    check_val("flush_even_valid", 64'(out_valid), 64'd0);
    check_val("flush_even_level", 64'(fifo_level), 64'd0);
    cycle(1'b1, 16'd5, 1'b0, 1'b1);
    cycle(1'b1, 16'd6, 1'b1, 1'b0);
    expect_head("flush_vs_sample", 16'd5, 16'd6, 17'd11);
    drain(2);

    // Reset with two pairs queued and an even sample pending.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
    apply_reset();
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_level", 64'(fifo_level), 64'd0);
    cycle(1'b1, 16'd20, 1'b0, 1'b0);
    cycle(1'b1, 16'd21, 1'b0, 1'b0);
    expect_head("rst_first_pair", 16'd20, 16'd21, 17'd41);
    drain(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       d = 16'h7FFF;
        1:       d = 16'h8000;
        default: d = 16'($urandom);
      endcase
      cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) != 0));
    end
    drain(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_l2_input_deinterleaver.md
Name: fir_l2_input_deinterleaver

Overview:
Input-side feeder for the reduced-complexity L=2 parallel FIR.
- Accepts a serial stream of signed samples under valid/ready.
- Groups consecutive samples into even/odd polyphase pairs (x[2k], x[2k+1]).
- Computes the fast-FIR pre-add term x[2k]+x[2k+1].
- Buffers completed pairs in a small FIFO so the parallel filter core can apply backpressure.

Parameters:
- DATA_IN_WIDTH, 16: sample width, signed two's complement.
- PAIR_FIFO_DEPTH, 4: pair FIFO entries; must be a power of 2 and ≥2.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: data_in is valid.
- in_ready, output, 1: block accepts data_in this cycle.
- data_in, input, DATA_IN_WIDTH: serial sample, signed.
- flush, input, 1: close a half-filled pair by zero-padding the odd sample.
- out_valid, output, 1: a pair is available.
- out_ready, input, 1: downstream consumes the pair this cycle.
- out_even, output, DATA_IN_WIDTH: x[2k], signed.
- out_odd, output, DATA_IN_WIDTH: x[2k+1], signed.
- out_sum, output, DATA_IN_WIDTH+1: out_even + out_odd, signed.
- fifo_level, output, $clog2(PAIR_FIFO_DEPTH)+1: number of stored pairs.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports named clk and reset_n.
- Reset values: phase=EVEN, hold register=0, FIFO empty, in_ready=1, out_valid=0, out_even/out_odd/out_sum=0, fifo_level=0.
- Accept handshake: a sample is accepted when in_valid && in_ready.
- Phase FSM, two states:
  - EVEN: an accepted sample goes into the hold register; go to ODD. Nothing is pushed to the FIFO.
  - ODD: an accepted sample pushes {hold, data_in}; go to EVEN.
- in_ready:
  - EVEN: 1, always.
  - ODD: !full || (out_valid && out_ready). Simultaneous push and pop on a full FIFO is legal.
- Flush:
  - In ODD with in_valid=0, flush && (!full || pop) pushes {hold, 0}; go to EVEN.
  - In ODD with in_valid=1, the real sample wins and flush is ignored that cycle.
  - In EVEN, flush has no effect.
- Output side:
  - First-word-fall-through: out_valid = !empty, and out_* show the head entry.
  - A pop occurs on out_valid && out_ready.
  - Outputs must be held stable while out_valid && !out_ready.
  - When empty, out_* = 0.
- Latency: a pair is visible at the outputs on the cycle after its odd sample (or flush) is accepted.
- Arithmetic: out_sum = sign-extend(even) + sign-extend(odd) at DATA_IN_WIDTH+1 bits. No overflow or saturation. Computed at push time and stored in the FIFO.
- FIFO pointers: wrap modulo PAIR_FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- fifo_level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Reset mid-operation: a pending even sample and all FIFO contents are discarded; no partial pair is emitted afterwards.

Optional Feature:
- Macro: DEINT_PAIR_CNT_EN.
- Defined:
  - Adds output port pair_count, 32 bits, reset 0.
  - Increments on every pop; wraps from 2^32-1 to 0.
  - Counts flush-padded pairs as well.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Package fir_l2_pkg:
  - typedef fir_l2_pair_t, a struct holding even, odd and sum.
  - phase enum {PH_EVEN, PH_ODD}.
  - L=2 constant and a width helper for sum width.
- Sub-module fir_l2_pair_fifo: synchronous FWFT FIFO of fir_l2_pair_t with push/pop/full/empty/level. The top block holds the phase FSM, hold register, pre-adder and flush logic.

Test Plan:
- Basic pairing: feed 1,2,3,4 back-to-back with out_ready=1 -> pairs (1,2,sum 3) then (3,4,sum 7); each out_valid appears one cycle after the odd sample.
- Sign and width: feed 0x7FFF,0x7FFF -> out_sum=0x0FFFE. Feed 0x8000,0x8000 -> out_sum=0x10000 (-65536). No wrap.
- Backpressure/full:
  - out_ready=0, feed 10 samples with DEPTH=4 -> 4 pairs stored, fifo_level=4.
  - in_ready drops in ODD phase after sample 9; the hold register keeps 9.
  - Release out_ready -> pairs in order, then (9,10) is accepted.
- Flush:
  - Feed 5, idle, assert flush -> pair (5,0,sum 5).
  - Flush in EVEN phase -> no output.
  - flush with in_valid in ODD (sample 6) -> pair (5,6).
- Simultaneous push/pop at full: FIFO full, out_ready=1, odd sample arrives -> accepted, fifo_level stays 4, order preserved.
- Reset mid-operation: assert reset_n=0 after an even sample with 2 pairs queued -> out_valid=0, fifo_level=0. The next two samples form the first pair. With DEINT_PAIR_CNT_EN defined, pair_count returns to 0.
